// File: rtl/hazard_control_unit.sv
// Hazard control unit for the 5-stage MIPS pipeline.
// Resolves load-use stalls, sequences the fixed-latency mult/div unit,
// and flushes the front end on taken branches. All pipeline-register
// write enables, bubble and flush controls are produced here.
module hazard_control_unit #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_RS,
    input  logic [4:0] ID_RT,
    input  logic       ID_UsesRT,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_RT,
    input  logic       ID_MulDiv,
    input  logic       ID_MfHiLo,
    input  logic       EX_BranchTaken,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       ID_EX_Bubble,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       MD_Start,
    output logic       MD_Busy,
    output logic       Stall
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] md_count;
    logic [CNT_W-1:0] md_count_nxt;

    logic load_use;
    logic md_hazard;
    logic stall_int;
    logic start_int;

    // Load-use hazard: load in EX writes a register the ID instruction reads; $0 never hazards
    always_comb begin
        load_use = 1'b0;
        if (ID_EX_MemRead && (ID_EX_RT != 5'd0)) begin
            if ((ID_EX_RT == ID_RS) || (ID_UsesRT && (ID_EX_RT == ID_RT))) begin
                load_use = 1'b1;
            end
        end
    end

    // Hazard resolution: branch flush beats stalls; issue only from RUN without a load-use stall
    always_comb begin
        md_hazard = (state == MD_BUSY) && (ID_MulDiv || ID_MfHiLo);
        stall_int = (load_use || md_hazard) && !EX_BranchTaken;
        start_int = ID_MulDiv && (state == RUN) && !load_use && !EX_BranchTaken;
    end

    // State and busy-counter register, synchronous reset abandons any mult/div
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            md_count <= CNT_ZERO;
        end else begin
            state    <= state_nxt;
            md_count <= md_count_nxt;
        end
    end

    // Next state: load the latency on issue, count down while busy, return to RUN on the last cycle
    always_comb begin
        state_nxt    = state;
        md_count_nxt = md_count;
        case (state)
            RUN: begin
                if (start_int) begin
                    state_nxt    = MD_BUSY;
                    md_count_nxt = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_count == CNT_ONE) begin
                    state_nxt    = RUN;
                    md_count_nxt = CNT_ZERO;
                end else begin
                    md_count_nxt = md_count - CNT_ONE;
                end
            end
            default: begin
                state_nxt    = RUN;
                md_count_nxt = CNT_ZERO;
            end
        endcase
    end

    // Pipeline controls, combinational from registered state and current inputs; reset forces a frozen front end
    always_comb begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        MD_Start     = 1'b0;
        MD_Busy      = 1'b0;
        Stall        = 1'b0;
        if (!rst) begin
            Stall        = stall_int;
            PC_Write     = !stall_int || EX_BranchTaken;
            IF_ID_Write  = !stall_int;
            ID_EX_Bubble = stall_int;
            IF_ID_Flush  = EX_BranchTaken;
            ID_EX_Flush  = EX_BranchTaken;
            MD_Start     = start_int;
            MD_Busy      = (state == MD_BUSY);
        end
    end

endmodule
